// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch/jump fetch flush,
// halt drain to global halt, and a saturating load-use stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned LOAD_LAT     = 1,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        i_clk,
  input  logic        i_nRst,
  input  logic [3:0]  i_rdReg1,
  input  logic [3:0]  i_rdReg2,
  input  logic        i_rdEn1,
  input  logic        i_rdEn2,
  input  logic [3:0]  i_exWrReg,
  input  logic        i_exWrRegEn,
  input  logic        i_exMemRd,
  input  logic        i_sawBr,
  input  logic        i_sawJ,
  input  logic        i_idHlt,
  output logic        o_stallPC,
  output logic        o_stallIFID,
  output logic        o_flushIFID,
  output logic        o_bubbleIDEX,
  output logic        o_hlt,
  output logic [1:0]  o_state,
  output logic [15:0] o_stallCnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       hazard;
  logic       stall_cyc;

  // Register 0 is hard-wired, so a load targeting it never blocks a reader.
  assign hazard = i_exMemRd & i_exWrRegEn & (i_exWrReg != 4'd0) &
                  ((i_rdEn1 & (i_rdReg1 == i_exWrReg)) |
                   (i_rdEn2 & (i_rdReg2 == i_exWrReg)));

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    o_stallPC    = 1'b0;
    o_stallIFID  = 1'b0;
    o_flushIFID  = 1'b0;
    o_bubbleIDEX = 1'b0;
    stall_cyc    = 1'b0;
    case (state)
      RUN: begin
        if (hazard) begin
          o_stallPC    = 1'b1;
          o_stallIFID  = 1'b1;
          o_bubbleIDEX = 1'b1;
          stall_cyc    = 1'b1;
          if (LOAD_LAT > 1) begin
            state_nxt = STALL;
            cnt_nxt   = 4'(LOAD_LAT - 1);
          end
        end else if (i_idHlt) begin
          o_stallPC   = 1'b1;
          o_flushIFID = 1'b1;
          state_nxt   = DRAIN;
          cnt_nxt     = 4'(DRAIN_CYCLES);
        end else if (i_sawBr | i_sawJ) begin
          o_flushIFID = 1'b1;
        end
      end
      STALL: begin
        o_stallPC    = 1'b1;
        o_stallIFID  = 1'b1;
        o_bubbleIDEX = 1'b1;
        stall_cyc    = 1'b1;
        cnt_nxt      = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = RUN;
      end
      DRAIN: begin
        o_stallPC    = 1'b1;
        o_flushIFID  = 1'b1;
        o_bubbleIDEX = 1'b1;
        cnt_nxt      = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = HALTED;
      end
      HALTED: begin
        o_stallPC    = 1'b1;
        o_flushIFID  = 1'b1;
        o_bubbleIDEX = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      state      <= RUN;
      cnt        <= '0;
      o_hlt      <= 1'b0;
      o_stallCnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      o_hlt <= (state_nxt == HALTED);
      if (stall_cyc && (o_stallCnt != '1)) o_stallCnt <= o_stallCnt + 16'd1;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (default params and LOAD_LAT=3/DRAIN_CYCLES=1)
// driven in parallel and compared every cycle against a remaining-cycles model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [3:0] rd_reg1 = '0, rd_reg2 = '0, ex_wr_reg = '0;
  logic       rd_en1 = 1'b0, rd_en2 = 1'b0, ex_wr_en = 1'b0, ex_mem_rd = 1'b0;
  logic       saw_br = 1'b0, saw_j = 1'b0, id_hlt = 1'b0;

  logic        o_pc[2], o_ifid[2], o_fl[2], o_bub[2], o_hl[2];
  logic [1:0]  o_st[2];
  logic [15:0] o_cnt[2];

  int checks = 0;
  int errors = 0;

  // model: cycles of stall/drain still to come after the current one
  int stall_left[2], drain_left[2], scnt[2];
  bit halted[2];
  int lat_p[2]   = '{1, 3};
  int drain_p[2] = '{3, 1};

  always #5 clk = ~clk;

  hazard_ctrl u_a (
    .i_clk(clk), .i_nRst(n_rst),
    .i_rdReg1(rd_reg1), .i_rdReg2(rd_reg2), .i_rdEn1(rd_en1), .i_rdEn2(rd_en2),
    .i_exWrReg(ex_wr_reg), .i_exWrRegEn(ex_wr_en), .i_exMemRd(ex_mem_rd),
    .i_sawBr(saw_br), .i_sawJ(saw_j), .i_idHlt(id_hlt),
    .o_stallPC(o_pc[0]), .o_stallIFID(o_ifid[0]), .o_flushIFID(o_fl[0]),
    .o_bubbleIDEX(o_bub[0]), .o_hlt(o_hl[0]), .o_state(o_st[0]), .o_stallCnt(o_cnt[0])
  );

  hazard_ctrl #(.LOAD_LAT(3), .DRAIN_CYCLES(1)) u_b (
    .i_clk(clk), .i_nRst(n_rst),
    .i_rdReg1(rd_reg1), .i_rdReg2(rd_reg2), .i_rdEn1(rd_en1), .i_rdEn2(rd_en2),
    .i_exWrReg(ex_wr_reg), .i_exWrRegEn(ex_wr_en), .i_exMemRd(ex_mem_rd),
    .i_sawBr(saw_br), .i_sawJ(saw_j), .i_idHlt(id_hlt),
    .o_stallPC(o_pc[1]), .o_stallIFID(o_ifid[1]), .o_flushIFID(o_fl[1]),
    .o_bubbleIDEX(o_bub[1]), .o_hlt(o_hl[1]), .o_state(o_st[1]), .o_stallCnt(o_cnt[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hazard();
    if (!(ex_mem_rd && ex_wr_en) || ex_wr_reg == 4'd0) return 1'b0;
    return (rd_en1 && rd_reg1 == ex_wr_reg) || (rd_en2 && rd_reg2 == ex_wr_reg);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      stall_left[d] = 0; drain_left[d] = 0; scnt[d] = 0; halted[d] = 1'b0;
    end
  endtask

  task automatic model_clock();
    bit haz;
    haz = model_hazard();
    for (int d = 0; d < 2; d++) begin
      if (halted[d]) begin
      end else if (drain_left[d] > 0) begin
        drain_left[d]--;
        if (drain_left[d] == 0) halted[d] = 1'b1;
      end else if (stall_left[d] > 0) begin
        stall_left[d]--;
        if (scnt[d] < 65535) scnt[d]++;
      end else if (haz) begin
        if (scnt[d] < 65535) scnt[d]++;
        stall_left[d] = lat_p[d] - 1;
      end else if (id_hlt) begin
        drain_left[d] = drain_p[d];
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic pc, ifid, fl, bub;
    logic [1:0] st;
    for (int d = 0; d < 2; d++) begin
      pc = 0; ifid = 0; fl = 0; bub = 0; st = 2'd0;
      if (halted[d]) begin
        pc = 1; fl = 1; bub = 1; st = 2'd3;
      end else if (drain_left[d] > 0) begin
        pc = 1; fl = 1; bub = 1; st = 2'd2;
      end else if (stall_left[d] > 0) begin
        pc = 1; ifid = 1; bub = 1; st = 2'd1;
      end else if (model_hazard()) begin
        pc = 1; ifid = 1; bub = 1;
      end else if (id_hlt) begin
        pc = 1; fl = 1;
      end else if (saw_br || saw_j) begin
        fl = 1;
      end
      chk($sformatf("%s.%0d.stallPC", tag, d),    32'(o_pc[d]),   32'(pc));
      chk($sformatf("%s.%0d.stallIFID", tag, d),  32'(o_ifid[d]), 32'(ifid));
      chk($sformatf("%s.%0d.flushIFID", tag, d),  32'(o_fl[d]),   32'(fl));
      chk($sformatf("%s.%0d.bubbleIDEX", tag, d), 32'(o_bub[d]),  32'(bub));
      chk($sformatf("%s.%0d.hlt", tag, d),        32'(o_hl[d]),   32'(halted[d]));
      chk($sformatf("%s.%0d.state", tag, d),      32'(o_st[d]),   32'(st));
      chk($sformatf("%s.%0d.stallCnt", tag, d),   32'(o_cnt[d]),  32'(scnt[d]));
    end
  endtask

  task automatic set_idle();
    rd_reg1 = '0; rd_reg2 = '0; ex_wr_reg = '0;
    rd_en1 = 0; rd_en2 = 0; ex_wr_en = 0; ex_mem_rd = 0;
    saw_br = 0; saw_j = 0; id_hlt = 0;
  endtask

  task automatic set_load_use(input logic [3:0] r);
    ex_mem_rd = 1; ex_wr_en = 1; ex_wr_reg = r; rd_reg1 = r; rd_en1 = 1;
  endtask

  task automatic settle(input string tag);
    #3;
    check_all(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset.%0d.state0", d), 32'(o_st[d]),  32'd0);
      chk($sformatf("reset.%0d.hlt0", d),   32'(o_hl[d]),  32'd0);
      chk($sformatf("reset.%0d.cnt0", d),   32'(o_cnt[d]), 32'd0);
    end
    set_idle();
    @(negedge clk);
    #1 n_rst = 1'b1;
    tick();
  endtask

  initial begin
    set_idle();
    model_reset();
    #2;
    do_reset();

    // load-use, r3
    set_load_use(4'd3);
    settle("lu");
    chk("lu.a.stallPC", 32'(o_pc[0]), 32'd1);
    chk("lu.a.bubble", 32'(o_bub[0]), 32'd1);
    chk("lu.a.cnt", 32'(o_cnt[0]), 32'd0);
    tick();
    set_idle();
    settle("lu1");
    chk("lu1.a.stallPC", 32'(o_pc[0]), 32'd0);
    chk("lu1.a.cnt", 32'(o_cnt[0]), 32'd1);
    chk("lu1.b.state", 32'(o_st[1]), 32'd1);
    tick();
    settle("lu2");
    chk("lu2.b.state", 32'(o_st[1]), 32'd1);
    tick();
    settle("lu3");
    chk("lu3.b.state", 32'(o_st[1]), 32'd0);
    chk("lu3.b.cnt", 32'(o_cnt[1]), 32'd3);
    tick();

    // no false hazards
    set_load_use(4'd0);
    settle("r0");
    chk("r0.a.stallPC", 32'(o_pc[0]), 32'd0);
    tick();
    set_load_use(4'd5); rd_en1 = 0;
    settle("noen");
    chk("noen.a.stallPC", 32'(o_pc[0]), 32'd0);
    tick();
    set_load_use(4'd5); ex_mem_rd = 0;
    settle("noload");
    chk("noload.a.stallPC", 32'(o_pc[0]), 32'd0);
    tick();
    set_idle();
    rd_en2 = 1; rd_reg2 = 4'd9; ex_mem_rd = 1; ex_wr_en = 1; ex_wr_reg = 4'd9;
    settle("rd2");
    chk("rd2.a.stallPC", 32'(o_pc[0]), 32'd1);
    tick();
    set_idle();
    for (int i = 0; i < 3; i++) begin settle("rd2d"); tick(); end

    // taken branch / jump with hazard
    saw_br = 1;
    settle("br");
    chk("br.a.flush", 32'(o_fl[0]), 32'd1);
    chk("br.a.stallPC", 32'(o_pc[0]), 32'd0);
    tick();
    set_idle();
    settle("br1");
    chk("br1.a.flush", 32'(o_fl[0]), 32'd0);
    tick();
    saw_j = 1; set_load_use(4'd7); id_hlt = 1;
    settle("jhz");
    chk("jhz.a.flush", 32'(o_fl[0]), 32'd0);
    chk("jhz.a.stallPC", 32'(o_pc[0]), 32'd1);
    tick();
    set_idle();
    for (int i = 0; i < 3; i++) begin settle("jhzd"); tick(); end

    // halt drain to HALTED
    do_reset();
    id_hlt = 1; saw_br = 1;
    settle("h0");
    chk("h0.a.flush", 32'(o_fl[0]), 32'd1);
    chk("h0.a.stallPC", 32'(o_pc[0]), 32'd1);
    tick();
    set_idle();
    for (int i = 1; i <= 3; i++) begin
      settle("hd");
      chk($sformatf("hd%0d.a.state", i), 32'(o_st[0]), 32'd2);
      chk($sformatf("hd%0d.a.hlt", i), 32'(o_hl[0]), 32'd0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 2) set_load_use(4'd2);
      settle("hh");
      chk($sformatf("hh%0d.a.state", i), 32'(o_st[0]), 32'd3);
      chk($sformatf("hh%0d.a.hlt", i), 32'(o_hl[0]), 32'd1);
      chk($sformatf("hh%0d.a.stallPC", i), 32'(o_pc[0]), 32'd1);
      tick();
    end

    // reset in the middle of drain
    do_reset();
    id_hlt = 1;
    settle("m0");
    tick();
    set_idle();
    settle("m1");
    tick();
    settle("m2");
    chk("m2.a.state", 32'(o_st[0]), 32'd2);
    #2;
    do_reset();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      rd_reg1   = 4'($urandom_range(0, 3));
      rd_reg2   = 4'($urandom_range(0, 3));
      ex_wr_reg = 4'($urandom_range(0, 3));
      rd_en1    = ($urandom_range(0, 3) != 0);
      rd_en2    = ($urandom_range(0, 3) != 0);
      ex_wr_en  = ($urandom_range(0, 3) != 0);
      ex_mem_rd = ($urandom_range(0, 1) != 0);
      saw_br    = ($urandom_range(0, 3) == 0);
      saw_j     = ($urandom_range(0, 5) == 0);
      id_hlt    = ($urandom_range(0, 15) == 0);
      settle("rnd");
      tick();
    end

    // saturation of the stall counter
    do_reset();
    set_load_use(4'd4);
    for (int i = 0; i < 65540; i++) tick();
    settle("sat");
    chk("sat.a.cnt", 32'(o_cnt[0]), 32'h0000FFFF);
    chk("sat.b.cnt", 32'(o_cnt[1]), 32'h0000FFFF);
    tick();
    settle("sat1");
    chk("sat1.a.cnt", 32'(o_cnt[0]), 32'h0000FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 16-bit, 5-stage (IF, ID, EX, MEM, WB) core. It watches the register reads decoded in ID and the load in EX to insert load-use stalls. It flushes the wrong-path fetch after a taken branch or jump resolved in ID, and drains the pipeline on a halt instruction before raising the global halt. It drives the PC, IF/ID and ID/EX pipeline-register controls and keeps a saturating stall-cycle counter for performance checks.

## Interface
- LOAD_LAT, 1: stall cycles per load-use hazard (1..15).
- DRAIN_CYCLES, 3: cycles between halt leaving ID and `o_hlt` assertion (1..15).
- i_clk  in  1  system clock, all state on rising edge.
- i_nRst  in  1  asynchronous active-low reset.
- i_rdReg1, i_rdReg2  in  4  source registers decoded in ID.
- i_rdEn1, i_rdEn2  in  1  source register actually read in ID.
- i_exWrReg  in  4  destination register of the instruction in EX.
- i_exWrRegEn  in  1  EX instruction writes the register file.
- i_exMemRd  in  1  EX instruction is a load.
- i_sawBr, i_sawJ  in  1  taken branch / jump resolved in ID this cycle.
- i_idHlt  in  1  halt instruction decoded in ID.
- o_stallPC  out  1  hold PC.
- o_stallIFID  out  1  hold IF/ID register.
- o_flushIFID  out  1  load NOP into IF/ID.
- o_bubbleIDEX  out  1  load NOP (all enables 0) into ID/EX.
- o_hlt  out  1  registered global halt, drives register-file dump.
- o_state  out  2  RUN=0, STALL=1, DRAIN=2, HALTED=3.
- o_stallCnt  out  16  load-use stall cycles, saturating.

## Operation
- Load-use hazard (combinational): `i_exMemRd & i_exWrRegEn & (i_exWrReg != 0) & ((i_rdEn1 & i_rdReg1 == i_exWrReg) | (i_rdEn2 & i_rdReg2 == i_exWrReg))`. Register 0 never causes a hazard.
- The four pipeline controls are Mealy outputs of the state and the current inputs.
- RUN, priority order:
  - Hazard: assert stallPC, stallIFID and bubbleIDEX. If LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1. Otherwise stay in RUN.
  - Else i_idHlt: assert stallPC and flushIFID, go to DRAIN with cnt=DRAIN_CYCLES.
  - Else i_sawBr or i_sawJ: assert flushIFID only; PC loads the target normally.
  - Else: all controls 0.
- STALL: assert stallPC, stallIFID and bubbleIDEX. Decrement cnt; when cnt==1, go to RUN. Branch and halt inputs are ignored because the ID instruction is held.
- DRAIN: assert stallPC, flushIFID and bubbleIDEX. Decrement cnt; when cnt==1, go to HALTED.
- HALTED: assert stallPC, flushIFID, bubbleIDEX and o_hlt. Leave only by reset.
- Simultaneous events:
  - Hazard together with halt or branch: the stall wins, and the ID instruction is re-evaluated after the stall.
  - Halt together with branch: halt wins.
- o_stallCnt increments by 1 in every cycle where a load-use stall is asserted (RUN hazard cycle or STALL state). It saturates at 0xFFFF and does not count in DRAIN or HALTED.
- cnt is a 4-bit internal register.

## Timing
- Reset (asynchronous, i_nRst=0): state=RUN, cnt=0, o_hlt=0, o_stallCnt=0. All pipeline controls then evaluate from RUN.
- Reset mid-STALL or mid-DRAIN returns immediately to RUN with all counters cleared.
- Load-use at cycle t: stalls cover cycles t..t+LOAD_LAT-1. The dependent instruction leaves ID at the end of cycle t+LOAD_LAT.
- Taken branch at cycle t: flushIFID is high in cycle t only; the target instruction is in ID at t+2.
- Halt in ID at cycle t:
  - DRAIN covers t+1..t+DRAIN_CYCLES.
  - o_hlt rises at t+DRAIN_CYCLES+1 and stays high.
  - With the default DRAIN_CYCLES=3, the halt instruction has passed WB when o_hlt rises.
- o_state reflects the registered state with no extra delay.

## Test plan
- Load-use, default params: EX load r3 (exMemRd=1, exWrRegEn=1, exWrReg=3); ID reads rdReg1=3 with rdEn1=1 -> one cycle of stallPC/stallIFID/bubbleIDEX=1, o_stallCnt goes 0->1, no stall in the next cycle.
- No false hazards:
  - Same as the load-use case but exWrReg=0 -> no stall.
  - rdEn1=0 with a matching register -> no stall.
  - exMemRd=0 with a matching register -> no stall.
- LOAD_LAT=3: a single hazard -> stall for exactly 3 cycles, o_state 0->1->1->0, o_stallCnt=3.
- Taken branch: i_sawBr=1 in RUN -> flushIFID=1 for that cycle only, stallPC=0. With i_sawJ=1 and a hazard in the same cycle -> stall only, no flush.
- Halt with default params: i_idHlt=1 at cycle t -> o_state=2 for t+1..t+3, o_hlt=1 from t+4 onward, stallPC stays 1. Assert i_nRst=0 at t+2 -> immediately o_state=0 and o_hlt=0.
- Saturation: force 65536 stall cycles -> o_stallCnt holds at 0xFFFF.
